// File: rtl/uart_tx_datapath.sv
// ---------------------------------------------------------------------------
// uart_tx_datapath
//
// UART transmit datapath driven by the TX control FSM. Holds the character
// being sent, counts data bits, accumulates parity and drives the registered
// serial line.
//
// Optional feature macro: UART_TX_BREAK_EN
//   defined   : tx_break forces the line low on the next clk (internal state
//               keeps updating normally).
//   undefined : tx_break is accepted but ignored; no break logic is built.
//
// Ports
//   clk               system clock
//   reset             asynchronous, active-high reset
//   tx_clk_en         baud-rate enable; all strobe-driven updates need it high
//   tx_data_in        character from the TX queue read port
//   data_len          configured data bits per frame (legal 5..DATA_WIDTH)
//   parity_odd        1 = odd parity, 0 = even parity
//   tx_bits_cnt_reset clear bit counter
//   tx_bits_cnt_en    increment bit counter (saturating)
//   tx_shift_reg_we   load shift register and latch frame length
//   tx_shift_reg_se   shift register right by one (LSB first)
//   tx_parity_reset   clear parity accumulator
//   tx_parity_we      XOR current data bit into parity accumulator
//   tx_out_sel        line source: 00 start, 01 idle/stop, 10 data, 11 parity
//   tx_break          break request
//   tx_bits_cnt_top   all latched data bits have been sent
//   tx                serial line, registered
// ---------------------------------------------------------------------------
module uart_tx_datapath #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_clk_en,
    input  logic [DATA_WIDTH-1:0] tx_data_in,
    input  logic [3:0]            data_len,
    input  logic                  parity_odd,
    input  logic                  tx_bits_cnt_reset,
    input  logic                  tx_bits_cnt_en,
    input  logic                  tx_shift_reg_we,
    input  logic                  tx_shift_reg_se,
    input  logic                  tx_parity_reset,
    input  logic                  tx_parity_we,
    input  logic [1:0]            tx_out_sel,
    input  logic                  tx_break,
    output logic                  tx_bits_cnt_top,
    output logic                  tx
);

    localparam logic [3:0] FULL_LEN = 4'(DATA_WIDTH);
    localparam logic [3:0] MIN_LEN  = 4'd5;
    localparam logic [3:0] CNT_MAX  = 4'hF;

    localparam logic [1:0] SEL_START  = 2'b00;
    localparam logic [1:0] SEL_IDLE   = 2'b01;
    localparam logic [1:0] SEL_DATA   = 2'b10;
    localparam logic [1:0] SEL_PARITY = 2'b11;

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [3:0]            len_q, len_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;

    logic [3:0]            eff_len;
    logic                  data_bit;
    logic                  parity_bit;
    logic                  mux_bit;

    // ------------------------------------------------------------------
    // Effective frame length: out-of-range requests are clamped into the
    // legal window so the counter compare always terminates the frame.
    // ------------------------------------------------------------------
    always_comb begin
        eff_len = data_len;
        if (data_len == 4'd0 || data_len > FULL_LEN) begin
            eff_len = FULL_LEN;
        end else if (data_len < MIN_LEN) begin
            eff_len = MIN_LEN;
        end
    end

    assign data_bit   = shift_q[0];
    assign parity_bit = par_q ^ parity_odd;

    // ------------------------------------------------------------------
    // Shift register and latched length. Load has priority over shift.
    // ------------------------------------------------------------------
    always_comb begin
        shift_d = shift_q;
        len_d   = len_q;
        if (tx_clk_en) begin
            if (tx_shift_reg_we) begin
                shift_d = tx_data_in;
                len_d   = eff_len;
            end else if (tx_shift_reg_se) begin
                shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Bit counter: clear wins over increment, increment saturates.
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        if (tx_clk_en) begin
            if (tx_bits_cnt_reset) begin
                cnt_d = '0;
            end else if (tx_bits_cnt_en && cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Parity accumulator: clear wins over accumulate. The accumulated bit
    // is the one currently on shift_q[0], i.e. before this edge's shift.
    // ------------------------------------------------------------------
    always_comb begin
        par_d = par_q;
        if (tx_clk_en) begin
            if (tx_parity_reset) begin
                par_d = 1'b0;
            end else if (tx_parity_we) begin
                par_d = par_q ^ data_bit;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line source mux. The line register runs every clk so the output
    // latency from tx_out_sel is always one cycle.
    // ------------------------------------------------------------------
    always_comb begin
        mux_bit = 1'b1;
        unique case (tx_out_sel)
            SEL_START:  mux_bit = 1'b0;
            SEL_IDLE:   mux_bit = 1'b1;
            SEL_DATA:   mux_bit = data_bit;
            SEL_PARITY: mux_bit = parity_bit;
            default:    mux_bit = 1'b1;
        endcase
    end

`ifdef UART_TX_BREAK_EN
    always_comb begin
        tx_d = mux_bit;
        if (tx_break) begin
            tx_d = 1'b0;
        end
    end
`else
    logic unused_tx_break;
    assign unused_tx_break = tx_break;

    always_comb begin
        tx_d = mux_bit;
    end
`endif

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            len_q   <= FULL_LEN;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            shift_q <= shift_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    assign tx_bits_cnt_top = (cnt_q == len_q);
    assign tx              = tx_q;

endmodule

// File: tb/tb_uart_tx_datapath.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_datapath
//
// Self-checking bench for uart_tx_datapath. A behavioural model (word +
// shift position, integer counter, parity flag) predicts tx and
// tx_bits_cnt_top every cycle; directed frames add literal expectations on
// the serial bit sequence and on the number of data bits per frame.
// ---------------------------------------------------------------------------
module tb_uart_tx_datapath;

    localparam int DW = 8;

    logic          clk;
    logic          reset;
    logic          tx_clk_en;
    logic [DW-1:0] tx_data_in;
    logic [3:0]    data_len;
    logic          parity_odd;
    logic          tx_bits_cnt_reset;
    logic          tx_bits_cnt_en;
    logic          tx_shift_reg_we;
    logic          tx_shift_reg_se;
    logic          tx_parity_reset;
    logic          tx_parity_we;
    logic [1:0]    tx_out_sel;
    logic          tx_break;
    logic          tx_bits_cnt_top;
    logic          tx;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_datapath #(.DATA_WIDTH(DW)) dut (
        .clk               (clk),
        .reset             (reset),
        .tx_clk_en         (tx_clk_en),
        .tx_data_in        (tx_data_in),
        .data_len          (data_len),
        .parity_odd        (parity_odd),
        .tx_bits_cnt_reset (tx_bits_cnt_reset),
        .tx_bits_cnt_en    (tx_bits_cnt_en),
        .tx_shift_reg_we   (tx_shift_reg_we),
        .tx_shift_reg_se   (tx_shift_reg_se),
        .tx_parity_reset   (tx_parity_reset),
        .tx_parity_we      (tx_parity_we),
        .tx_out_sel        (tx_out_sel),
        .tx_break          (tx_break),
        .tx_bits_cnt_top   (tx_bits_cnt_top),
        .tx                (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [DW-1:0] m_word;
    int            m_pos;     // number of bits already shifted out
    int            m_cnt;
    int            m_len;
    bit            m_par;
    bit            m_tx;

    function automatic int eff_len(input int dl);
        if (dl >= 5 && dl <= DW) return dl;
        if (dl == 0 || dl > DW)  return DW;
        return 5;
    endfunction

    function automatic bit cur_bit();
        if (m_pos < DW) return m_word[m_pos];
        return 1'b0;
    endfunction

    function automatic bit line_value();
        bit v;
        case (tx_out_sel)
            2'd0:    v = 1'b0;
            2'd1:    v = 1'b1;
            2'd2:    v = cur_bit();
            default: v = m_par ^ parity_odd;
        endcase
`ifdef UART_TX_BREAK_EN
        if (tx_break) v = 1'b0;
`endif
        return v;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_word <= '0;
            m_pos  <= 0;
            m_cnt  <= 0;
            m_len  <= DW;
            m_par  <= 1'b0;
            m_tx   <= 1'b1;
        end else begin
            m_tx <= line_value();
            if (tx_clk_en) begin
                if (tx_shift_reg_we) begin
                    m_word <= tx_data_in;
                    m_pos  <= 0;
                    m_len  <= eff_len(int'(data_len));
                end else if (tx_shift_reg_se && m_pos < 64) begin
                    m_pos <= m_pos + 1;
                end
                if (tx_bits_cnt_reset)                 m_cnt <= 0;
                else if (tx_bits_cnt_en && m_cnt < 15) m_cnt <= m_cnt + 1;
                if (tx_parity_reset)   m_par <= 1'b0;
                else if (tx_parity_we) m_par <= m_par ^ cur_bit();
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        n_tests++;
        if (tx !== m_tx) begin
            n_fail++;
            $display("FAIL model_tx @%0t: got %b, expected %b", $time, tx, m_tx);
        end
        n_tests++;
        if (tx_bits_cnt_top !== (m_cnt == m_len)) begin
            n_fail++;
            $display("FAIL model_top @%0t: got %b, expected %b", $time,
                     tx_bits_cnt_top, (m_cnt == m_len));
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        tx_clk_en         = 1'b1;
        tx_bits_cnt_reset = 1'b0;
        tx_bits_cnt_en    = 1'b0;
        tx_shift_reg_we   = 1'b0;
        tx_shift_reg_se   = 1'b0;
        tx_parity_reset   = 1'b0;
        tx_parity_we      = 1'b0;
        tx_out_sel        = 2'b01;
        tx_break          = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One frame as the control FSM would sequence it. Data cycles continue
    // until the counter reports top (bounded). seq[i] is the line value in
    // baud cycle i.
    task automatic send_frame(input logic [7:0] w, input logic [3:0] dl,
                              input logic [3:0] dl_after, input bit odd,
                              input bit pen, output logic [31:0] seq,
                              output int ndata);
        int n;
        seq = '0;
        n   = 0;
        idle_inputs();
        tx_data_in        = w;
        data_len          = dl;
        parity_odd        = odd;
        tx_shift_reg_we   = 1'b1;
        tx_bits_cnt_reset = 1'b1;
        tx_parity_reset   = 1'b1;
        tx_out_sel        = 2'b00;
        step();
        seq[n] = tx; n++;
        idle_inputs();
        data_len = dl_after;
        ndata = 0;
        while (tx_bits_cnt_top !== 1'b1 && ndata < 16) begin
            tx_out_sel      = 2'b10;
            tx_shift_reg_se = 1'b1;
            tx_bits_cnt_en  = 1'b1;
            tx_parity_we    = 1'b1;
            step();
            seq[n] = tx; n++;
            ndata++;
        end
        idle_inputs();
        if (pen) begin
            tx_out_sel = 2'b11;
            step();
            seq[n] = tx; n++;
        end
        tx_out_sel = 2'b01;
        step();
        seq[n] = tx; n++;
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] seq;
        int          nd;

        idle_inputs();
        reset      = 1'b1;
        tx_data_in = '0;
        data_len   = 4'd8;
        parity_odd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_tx", tx, 1);
        chk("reset_top", tx_bits_cnt_top, 0);
        reset = 1'b0;
        step();

        // 0xA5, 8 bits, even parity: start, 1,0,1,0,0,1,0,1, parity 0, stop
        send_frame(8'hA5, 4'd8, 4'd8, 1'b0, 1'b1, seq, nd);
        chk("a5_even_seq", seq[10:0], {1'b1, 1'b0, 8'hA5, 1'b0});
        chk("a5_even_ndata", nd, 8);

        send_frame(8'hA5, 4'd8, 4'd8, 1'b1, 1'b1, seq, nd);
        chk("a5_odd_seq", seq[10:0], {1'b1, 1'b1, 8'hA5, 1'b0});

        send_frame(8'h1F, 4'd5, 4'd5, 1'b0, 1'b1, seq, nd);
        chk("1f_len5_seq", seq[7:0], {1'b1, 1'b1, 5'h1F, 1'b0});
        chk("1f_len5_ndata", nd, 5);

        // Length latched at load only
        send_frame(8'hFF, 4'd8, 4'd5, 1'b0, 1'b0, seq, nd);
        chk("len_change_mid_frame", nd, 8);
        send_frame(8'hFF, 4'd5, 4'd5, 1'b0, 1'b0, seq, nd);
        chk("len_next_frame", nd, 5);
        send_frame(8'h3C, 4'd3, 4'd3, 1'b0, 1'b0, seq, nd);
        chk("len3_clamp", nd, 5);
        send_frame(8'h3C, 4'd0, 4'd0, 1'b0, 1'b0, seq, nd);
        chk("len0_clamp", nd, 8);
        send_frame(8'h81, 4'd12, 4'd12, 1'b0, 1'b1, seq, nd);
        chk("len12_clamp", nd, 8);
        chk("len12_seq", seq[10:0], {1'b1, 1'b0, 8'h81, 1'b0});

        // Load wins over shift
        idle_inputs();
        data_len = 4'd8;
        tx_data_in = 8'h01; tx_shift_reg_we = 1'b1; step();
        tx_data_in = 8'h03; tx_shift_reg_se = 1'b1; step();
        idle_inputs(); tx_out_sel = 2'b10; step();
        chk("we_se_load_wins", tx, 1);

        // Counter clear wins over increment
        idle_inputs(); tx_bits_cnt_reset = 1'b1; step();
        idle_inputs(); tx_bits_cnt_en = 1'b1;
        repeat (7) step();
        tx_bits_cnt_reset = 1'b1; step();
        chk("cnt_reset_wins", tx_bits_cnt_top, 0);
        idle_inputs(); tx_bits_cnt_en = 1'b1;
        repeat (8) step();
        chk("cnt_after_reset_top", tx_bits_cnt_top, 1);

        // Parity clear wins over accumulate (shift_reg[0] is 1 here)
        idle_inputs(); parity_odd = 1'b0;
        tx_parity_reset = 1'b1; step();
        tx_parity_we = 1'b1; step();
        idle_inputs(); tx_out_sel = 2'b11; step();
        chk("par_reset_wins", tx, 0);

        // Strobes ignored while tx_clk_en is low
        idle_inputs();
        tx_clk_en = 1'b0; tx_data_in = 8'h00; tx_shift_reg_we = 1'b1;
        tx_shift_reg_se = 1'b1; tx_bits_cnt_reset = 1'b1; tx_parity_we = 1'b1;
        data_len = 4'd5; tx_out_sel = 2'b10;
        step();
        idle_inputs(); tx_out_sel = 2'b10; step();
        chk("en0_shift_hold", tx, 1);
        chk("en0_cnt_hold", tx_bits_cnt_top, 1);
        tx_out_sel = 2'b11; step();
        chk("en0_par_hold", tx, 0);
        data_len = 4'd8;

        // Break request during a data bit of value 1
        send_frame(8'hFF, 4'd8, 4'd8, 1'b0, 1'b0, seq, nd);
        idle_inputs();
        tx_data_in = 8'hFF; tx_shift_reg_we = 1'b1; tx_bits_cnt_reset = 1'b1;
        tx_out_sel = 2'b00; step();
        idle_inputs();
        tx_out_sel = 2'b10; tx_shift_reg_se = 1'b1; tx_bits_cnt_en = 1'b1;
        tx_break = 1'b1; step();
`ifdef UART_TX_BREAK_EN
        chk("break_forces_low", tx, 0);
`else
        chk("break_ignored", tx, 1);
`endif
        tx_break = 1'b0;
        repeat (7) step();
        chk("break_release_tx", tx, 1);
        chk("break_cnt_advanced", tx_bits_cnt_top, 1);

        // Asynchronous reset mid-frame while the line is low
        idle_inputs();
        tx_data_in = 8'h55; tx_shift_reg_we = 1'b1; tx_bits_cnt_reset = 1'b1;
        tx_out_sel = 2'b00; step();
        chk("pre_reset_start", tx, 0);
        idle_inputs(); tx_out_sel = 2'b10; tx_bits_cnt_en = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("async_reset_tx", tx, 1);
        step();
        reset = 1'b0;
        idle_inputs();
        step();
        chk("post_reset_top", tx_bits_cnt_top, 0);
        tx_out_sel = 2'b10; tx_bits_cnt_en = 1'b1;
        repeat (7) step();
        chk("post_reset_cnt7", tx_bits_cnt_top, 0);
        chk("post_reset_shift_zero", tx, 0);
        step();
        chk("post_reset_cnt8", tx_bits_cnt_top, 1);

        idle_inputs();
        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_datapath.md
Name: uart_tx_datapath

Overview:
UART transmit datapath driven by the TX control FSM. It holds the frame being sent, counts data bits, accumulates parity and drives the serial line.
- Input side: loads a character word from the TX queue read port.
- Control side: executes the FSM's per-baud strobes (load, shift, count, parity, output select) and returns the bit-count-top flag.
- Line side: drives the registered tx pin.

Parameters:
DATA_WIDTH, 8, width of queue word and shift register; maximum data bits per frame.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
tx_clk_en  input  1  baud-rate enable; all strobe-driven updates occur only when high
tx_data_in  input  DATA_WIDTH  character from TX queue read port, valid while tx_shift_reg_we high
data_len  input  4  configured data bits per frame; legal 5..DATA_WIDTH
parity_odd  input  1  1 = odd parity, 0 = even parity
tx_bits_cnt_reset  input  1  clear bit counter
tx_bits_cnt_en  input  1  increment bit counter
tx_shift_reg_we  input  1  load shift register and latch frame length
tx_shift_reg_se  input  1  shift register right by one (LSB first)
tx_parity_reset  input  1  clear parity accumulator
tx_parity_we  input  1  XOR current data bit into parity accumulator
tx_out_sel  input  2  line source: 00 start (0), 01 idle/stop (1), 10 data bit, 11 parity bit
tx_break  input  1  break request (see Optional Feature)
tx_bits_cnt_top  output  1  all latched data bits sent
tx  output  1  serial line, registered

Behaviour:
- Reset (async, active-high):
  - shift_reg=0, bit_cnt=0, parity_acc=0, len_q=DATA_WIDTH, tx=1.
  - tx_bits_cnt_top follows combinationally from reset values (0≠len_q → 0).
- Update gating:
  - Shift, counter, parity and len_q update only on a clk edge with tx_clk_en=1 and the relevant strobe high.
  - Strobes with tx_clk_en=0 are ignored.
- Shift register:
  - we → shift_reg<=tx_data_in and len_q<=effective data_len.
  - se → shift_reg<={1'b0, shift_reg[DATA_WIDTH-1:1]}.
  - we and se together: load wins.
- Effective length:
  - data_len in 5..DATA_WIDTH is used as-is.
  - 0 or >DATA_WIDTH → DATA_WIDTH; 1..4 → 5.
  - len_q is latched only at load, so a data_len change mid-frame does not affect the current frame.
- Bit counter (4-bit):
  - cnt_reset → 0; cnt_en → +1 saturating at 15.
  - Both set: reset wins.
  - tx_bits_cnt_top = (bit_cnt == len_q), combinational.
- Parity:
  - parity_reset → 0; parity_we → parity_acc ^= shift_reg[0].
  - Both set: reset wins.
  - Parity bit = parity_acc ^ parity_odd.
- Output:
  - tx is registered and updates every clk (not gated by tx_clk_en) from the tx_out_sel mux: 00→0, 01→1, 10→shift_reg[0], 11→parity bit.
  - Fixed latency: 1 clk from tx_out_sel to tx.
- Frame timing with the control FSM:
  - Load cycle: start bit (sel 00).
  - N data cycles: sel 10 with shift, count and parity strobes.
  - Optional parity cycle: sel 11.
  - Stop cycle(s): sel 01.
  - Each data bit is presented before the edge that shifts it out and accumulates it.
- Reset mid-frame: tx returns to 1 immediately (asynchronously); no partial state survives.

Optional Feature:
UART_TX_BREAK_EN
- Defined: tx_break=1 forces tx to 0 on the next clk, overriding tx_out_sel; internal shift/counter/parity state continues to update normally. Release restores the mux output on the next clk.
- Undefined: the tx_break port exists but is ignored; no break logic is synthesized.

Test Plan:
- Reset asserted mid-frame while tx=0 → tx=1 asynchronously; after release, counter=0 and tx_bits_cnt_top=0.
- 0xA5, data_len=8, even parity, strobe sequence as FSM → tx per baud: 0,1,0,1,0,0,1,0,1, parity 0, stop 1; top asserted after 8th shift.
- 0xA5 with parity_odd=1 → parity bit 1; 0x1F with data_len=5, even parity → data bits 1,1,1,1,1, parity 1, top after 5 counts.
- data_len changed 8→5 after load of 0xFF → frame still sends 8 data bits; next frame sends 5. data_len=3 → 5 bits; data_len=0 → 8 bits.
- Simultaneous we+se, cnt_reset+cnt_en, parity_reset+parity_we with tx_clk_en=1 → load/reset win. Same strobes with tx_clk_en=0 → no state change.
- With UART_TX_BREAK_EN: tx_break=1 during a data bit → tx=0 next clk, counter still advances; tx_break=0 → tx follows mux. Without the macro → tx_break has no effect.
